// File: rtl/lsq_pkg.sv
// LSQ shared package: sizes, status and bus encodings, entry
// layout and the load alignment/extension helper.
package lsq_pkg;

   localparam int XLEN        = 32;
   localparam int PREG_NUMBER = 64;
   localparam int LSQ_DEPTH   = 8;
   localparam int PW          = $clog2(PREG_NUMBER);
   localparam int IW          = $clog2(LSQ_DEPTH);

   typedef enum logic [1:0] {
      FULL_NONE = 2'd0,
      ONE_LEFT  = 2'd1,
      FULL      = 2'd2
   } STRUCTURE_FULL;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef struct packed {
      logic            valid;
      logic            is_store;
      logic [2:0]      funct;
      logic [PW-1:0]   dest;
      logic            addr_valid;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
      logic            done;
      logic            retired;
   } lsq_entry_t;

   // Pick the addressed bytes out of the 64-bit beat and extend.
   function automatic logic [XLEN-1:0] load_align(
      input logic [63:0] raw,
      input logic [2:0]  off,
      input logic [2:0]  funct
   );
      logic [XLEN-1:0] w;
      logic [XLEN-1:0] r;
      w = XLEN'(raw >> {off, 3'b000});
      unique case (funct[1:0])
         SIZE_BYTE: r = funct[2] ?
            {{(XLEN-8){1'b0}}, w[7:0]} :
            {{(XLEN-8){w[7]}}, w[7:0]};
         SIZE_HALF: r = funct[2] ?
            {{(XLEN-16){1'b0}}, w[15:0]} :
            {{(XLEN-16){w[15]}}, w[15:0]};
         default:   r = w;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsq.sv
// Load/store queue: circular buffer, in-order memory issue from
// the head with one outstanding request, CDB completion port.
module lsq
   import lsq_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                dispatch_mem_en_i,
   input  logic [1:0][2:0]           mem_funct_i,
   input  logic [1:0][6:0]           opcode_dispatch_i,
   input  logic [1:0][PW-1:0]        dispatch_dest_reg_i,
   input  logic                      execute_en_i,
   input  logic [XLEN-1:0]           opa,
   input  logic [XLEN-1:0]           opb,
   input  logic [XLEN-1:0]           rs2_value_i,
   input  logic [PW-1:0]             dest_reg_i,
   input  logic [1:0]                retire_mem_en_i,
   input  logic [1:0]                branch_recover_i,
   input  logic                      complete_en_i,
   output STRUCTURE_FULL             lsq_full,
   output logic                      ready_o,
   output logic                      done_o,
   output logic                      regfile_wr_en_o,
   output logic [PW-1:0]             dest_reg_o,
   output logic [XLEN-1:0]           result_o,
   input  logic                      mem_valid_i,
   input  logic [63:0]               mem_data_i,
   input  logic [3:0]                mem_response_i,
   input  logic [3:0]                mem_tag_i,
   output logic [XLEN-1:0]           mem_address_o,
   output logic [1:0]                mem_command_o,
   output logic [63:0]               mem_wdata_o,
   output logic [2:0]                mem_size_o,
   output logic [XLEN-1:0]           debug_store_data,
   output logic [XLEN-1:0]           debug_store_address
);

   lsq_entry_t      q [LSQ_DEPTH];
   logic [IW:0]     head, tail;
   logic            load_wait, load_have;
   logic [3:0]      load_tag;
   logic [XLEN-1:0] load_result;

   logic [IW:0]     count, free_slots, n_ret;
   logic [IW:0]     alloc_cnt, free_cnt;
   logic [IW-1:0]   hi, hi1, ti, p;
   logic [IW-1:0]   exec_idx, st_idx;
   logic [LSQ_DEPTH-1:0] ret_mark;
   logic [1:0]      ret_cnt, marked;
   logic            exec_hit, st_hit, flush;
   logic            a0, a1, ld_issue, st_issue;
   logic            accept, ld_return;
   logic            cmp_load, cmp_store;
   logic            head_ret, free0, free1;
   lsq_entry_t      h;
   logic            unused_ok;

   assign unused_ok = ^dest_reg_i;

   assign flush      = branch_recover_i != 2'b00;
   assign count      = tail - head;
   assign free_slots = (IW+1)'(LSQ_DEPTH) - count;
   assign hi         = head[IW-1:0];
   assign hi1        = hi + IW'(1);
   assign ti         = tail[IW-1:0];
   assign h          = q[hi];
   assign ret_cnt    = {1'b0, retire_mem_en_i[0]} +
                       {1'b0, retire_mem_en_i[1]};

   always_comb begin
      lsq_full = FULL_NONE;
      if (free_slots == '0)
         lsq_full = FULL;
      else if (free_slots == (IW+1)'(1))
         lsq_full = ONE_LEFT;
   end

   // Walk oldest-first: retire marking, exec target, store completion.
   always_comb begin
      ret_mark = '0;
      marked   = '0;
      n_ret    = '0;
      exec_hit = 1'b0;
      exec_idx = '0;
      st_hit   = 1'b0;
      st_idx   = '0;
      p        = '0;
      for (int i = 0; i < LSQ_DEPTH; i++) begin
         p = hi + IW'(i);
         if (q[p].valid) begin
            if (!q[p].retired && marked < ret_cnt) begin
               ret_mark[p] = 1'b1;
               marked      = marked + 2'd1;
            end
            if (q[p].retired || ret_mark[p])
               n_ret = n_ret + (IW+1)'(1);
            if (!exec_hit && !q[p].addr_valid) begin
               exec_hit = 1'b1;
               exec_idx = p;
            end
            if (!st_hit && q[p].is_store &&
                q[p].addr_valid && !q[p].done) begin
               st_hit = 1'b1;
               st_idx = p;
            end
         end
      end
   end

   assign a0 = dispatch_mem_en_i[0] && free_slots != '0 && !flush;
   assign a1 = dispatch_mem_en_i[1] && !flush &&
               free_slots > (IW+1)'(a0);
   assign alloc_cnt = (IW+1)'(a0) + (IW+1)'(a1);

   assign ld_issue = mem_valid_i && h.valid && !h.is_store &&
                     h.addr_valid && !h.done &&
                     !load_wait && !load_have;
   assign st_issue = mem_valid_i && h.valid && h.is_store &&
                     h.addr_valid && h.retired;
   assign accept   = (ld_issue || st_issue) && mem_response_i != 4'd0;
   assign ld_return = load_wait && load_tag != 4'd0 &&
                      mem_tag_i == load_tag;

   always_comb begin
      mem_command_o = BUS_NONE;
      mem_address_o = '0;
      mem_size_o    = '0;
      mem_wdata_o   = '0;
      if (ld_issue || st_issue) begin
         mem_command_o = ld_issue ? BUS_LOAD : BUS_STORE;
         mem_address_o = {h.addr[XLEN-1:3], 3'b000};
         mem_size_o    = {1'b0, h.funct[1:0]};
      end
      if (st_issue)
         mem_wdata_o = 64'(h.data) << {h.addr[2:0], 3'b000};
   end

   assign ready_o         = exec_hit;
   assign done_o          = load_have || st_hit;
   assign regfile_wr_en_o = load_have;
   assign dest_reg_o      = load_have ? h.dest :
                            st_hit ? q[st_idx].dest : '0;
   assign result_o        = load_have ? load_result : '0;
   assign cmp_load        = load_have && complete_en_i;
   assign cmp_store       = !load_have && st_hit && complete_en_i;

   assign head_ret = h.retired || ret_mark[hi];
   assign free0 = h.valid && ((st_issue && accept) ||
                  (!h.is_store && h.done && head_ret));
   assign free1 = free0 && q[hi1].valid && !q[hi1].is_store &&
                  q[hi1].done && (q[hi1].retired || ret_mark[hi1]);
   assign free_cnt = (IW+1)'(free0) + (IW+1)'(free1);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LSQ_DEPTH; i++)
            q[i] <= '0;
         head                <= '0;
         tail                <= '0;
         load_wait           <= 1'b0;
         load_have           <= 1'b0;
         load_tag            <= '0;
         load_result         <= '0;
         debug_store_data    <= '0;
         debug_store_address <= '0;
      end else begin
         for (int i = 0; i < LSQ_DEPTH; i++) begin
            if (ret_mark[i])
               q[i].retired <= 1'b1;
            if (flush && !(q[i].retired || ret_mark[i]))
               q[i].valid <= 1'b0;
         end
         if (execute_en_i && exec_hit && !flush) begin
            q[exec_idx].addr_valid <= 1'b1;
            q[exec_idx].addr       <= opa + opb;
            q[exec_idx].data       <= rs2_value_i;
         end
         if (cmp_load)
            q[hi].done <= 1'b1;
         if (cmp_store)
            q[st_idx].done <= 1'b1;
         if (free0)
            q[hi].valid <= 1'b0;
         if (free1)
            q[hi1].valid <= 1'b0;
         if (a0)
            q[ti] <= '{1'b1,
               opcode_dispatch_i[0] == OP_STORE,
               mem_funct_i[0], dispatch_dest_reg_i[0],
               1'b0, '0, '0, 1'b0, 1'b0};
         if (a1)
            q[ti + IW'(a0)] <= '{1'b1,
               opcode_dispatch_i[1] == OP_STORE,
               mem_funct_i[1], dispatch_dest_reg_i[1],
               1'b0, '0, '0, 1'b0, 1'b0};

         if (ld_issue && accept) begin
            load_wait <= 1'b1;
            load_tag  <= mem_response_i;
         end
         if (ld_return) begin
            load_wait   <= 1'b0;
            load_have   <= 1'b1;
            load_result <= load_align(mem_data_i,
                              h.addr[2:0], h.funct);
         end
         if (cmp_load)
            load_have <= 1'b0;
         // A squashed head load must not pick up its late data.
         if (flush && !head_ret) begin
            load_wait <= 1'b0;
            load_have <= 1'b0;
         end
         if (st_issue && accept) begin
            debug_store_data    <= h.data;
            debug_store_address <= h.addr;
         end

         head <= head + free_cnt;
         tail <= flush ? head + n_ret : tail + alloc_cnt;
      end
   end

endmodule

// File: tb/tb_lsq.sv
// Directed bench for the LSQ: load/store flow, alignment,
// occupancy, branch recovery and reset during a request.
module tb_lsq;
   import lsq_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [1:0]           dispatch_mem_en_i;
   logic [1:0][2:0]      mem_funct_i;
   logic [1:0][6:0]      opcode_dispatch_i;
   logic [1:0][PW-1:0]   dispatch_dest_reg_i;
   logic                 execute_en_i;
   logic [XLEN-1:0]      opa, opb, rs2_value_i;
   logic [PW-1:0]        dest_reg_i;
   logic [1:0]           retire_mem_en_i;
   logic [1:0]           branch_recover_i;
   logic                 complete_en_i;
   STRUCTURE_FULL        lsq_full;
   logic                 ready_o, done_o, regfile_wr_en_o;
   logic [PW-1:0]        dest_reg_o;
   logic [XLEN-1:0]      result_o;
   logic                 mem_valid_i;
   logic [63:0]          mem_data_i;
   logic [3:0]           mem_response_i, mem_tag_i;
   logic [XLEN-1:0]      mem_address_o;
   logic [1:0]           mem_command_o;
   logic [63:0]          mem_wdata_o;
   logic [2:0]           mem_size_o;
   logic [XLEN-1:0]      debug_store_data, debug_store_address;

   int checks = 0;
   int errors = 0;

   lsq dut (
      .clk(clk), .reset(reset),
      .dispatch_mem_en_i(dispatch_mem_en_i),
      .mem_funct_i(mem_funct_i),
      .opcode_dispatch_i(opcode_dispatch_i),
      .dispatch_dest_reg_i(dispatch_dest_reg_i),
      .execute_en_i(execute_en_i),
      .opa(opa), .opb(opb), .rs2_value_i(rs2_value_i),
      .dest_reg_i(dest_reg_i),
      .retire_mem_en_i(retire_mem_en_i),
      .branch_recover_i(branch_recover_i),
      .complete_en_i(complete_en_i),
      .lsq_full(lsq_full), .ready_o(ready_o),
      .done_o(done_o), .regfile_wr_en_o(regfile_wr_en_o),
      .dest_reg_o(dest_reg_o), .result_o(result_o),
      .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
      .mem_response_i(mem_response_i), .mem_tag_i(mem_tag_i),
      .mem_address_o(mem_address_o),
      .mem_command_o(mem_command_o),
      .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
      .debug_store_data(debug_store_data),
      .debug_store_address(debug_store_address)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [1:0] en,
                       input logic [6:0] op,
                       input logic [2:0] f0, input logic [2:0] f1,
                       input logic [5:0] d0, input logic [5:0] d1);
      dispatch_mem_en_i      = en;
      opcode_dispatch_i[0]   = op;
      opcode_dispatch_i[1]   = op;
      mem_funct_i[0]         = f0;
      mem_funct_i[1]         = f1;
      dispatch_dest_reg_i[0] = d0;
      dispatch_dest_reg_i[1] = d1;
      step();
      dispatch_mem_en_i = 2'b00;
   endtask

   task automatic exec(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d);
      execute_en_i = 1'b1;
      opa = a; opb = b; rs2_value_i = d;
      step();
      execute_en_i = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      dispatch_mem_en_i = '0; mem_funct_i = '0;
      opcode_dispatch_i = '0; dispatch_dest_reg_i = '0;
      execute_en_i = 1'b0; opa = '0; opb = '0;
      rs2_value_i = '0; dest_reg_i = '0;
      retire_mem_en_i = '0; branch_recover_i = '0;
      complete_en_i = 1'b0; mem_valid_i = 1'b1;
      mem_data_i = '0; mem_response_i = '0; mem_tag_i = '0;
      step();
      reset = 1'b0;
      check("rst_full", 64'(lsq_full), 64'(FULL_NONE));
      check("rst_ready", 64'(ready_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_cmd", 64'(mem_command_o), 64'd0);
      check("rst_addr", 64'(mem_address_o), 64'd0);
      check("rst_dbg", 64'(debug_store_data), 64'd0);

      // lw at 0x104: word sits in the upper half of the beat
      disp(2'b01, OP_LOAD, 3'b010, 3'b000, 6'd5, 6'd0);
      check("lw_ready", 64'(ready_o), 64'd1);
      exec(32'h100, 32'h4, 32'h0);
      check("lw_ready0", 64'(ready_o), 64'd0);
      check("lw_cmd", 64'(mem_command_o), 64'd1);
      check("lw_addr", 64'(mem_address_o), 64'h100);
      check("lw_size", 64'(mem_size_o), 64'd2);
      mem_response_i = 4'd1;
      step();
      mem_response_i = 4'd0;
      check("lw_wait_cmd", 64'(mem_command_o), 64'd0);
      mem_tag_i = 4'd1; mem_data_i = 64'hDEADBEEF_00000000;
      step();
      mem_tag_i = 4'd0;
      check("lw_done", 64'(done_o), 64'd1);
      check("lw_wr", 64'(regfile_wr_en_o), 64'd1);
      check("lw_dest", 64'(dest_reg_o), 64'd5);
      check("lw_res", 64'(result_o), 64'hDEADBEEF);
      complete_en_i = 1'b1; step(); complete_en_i = 1'b0;
      check("lw_cmpl", 64'(done_o), 64'd0);
      retire_mem_en_i = 2'b01; step(); retire_mem_en_i = 2'b00;
      check("lw_free", 64'(lsq_full), 64'(FULL_NONE));

      // lb then lbu at 0x103, byte 3 = 0x80
      disp(2'b11, OP_LOAD, 3'b000, 3'b100, 6'd7, 6'd8);
      exec(32'h100, 32'h3, 32'h0);
      check("lb_cmd", 64'(mem_command_o), 64'd1);
      check("lb_size", 64'(mem_size_o), 64'd0);
      execute_en_i = 1'b1; opa = 32'h103; opb = 32'h0;
      mem_response_i = 4'd2;
      step();
      execute_en_i = 1'b0; mem_response_i = 4'd0;
      mem_tag_i = 4'd3; mem_data_i = 64'h0000_0000_8000_0000;
      step();
      check("lb_wrongtag", 64'(done_o), 64'd0);
      mem_tag_i = 4'd2; step(); mem_tag_i = 4'd0;
      check("lb_res", 64'(result_o), 64'hFFFFFF80);
      check("lb_dest", 64'(dest_reg_o), 64'd7);
      complete_en_i = 1'b1; step(); complete_en_i = 1'b0;
      check("lbu_blocked", 64'(mem_command_o), 64'd0);
      retire_mem_en_i = 2'b01; step(); retire_mem_en_i = 2'b00;
      check("lbu_cmd", 64'(mem_command_o), 64'd1);
      mem_response_i = 4'd5; step(); mem_response_i = 4'd0;
      mem_tag_i = 4'd5; step(); mem_tag_i = 4'd0;
      check("lbu_res", 64'(result_o), 64'h00000080);
      check("lbu_dest", 64'(dest_reg_o), 64'd8);
      complete_en_i = 1'b1; step(); complete_en_i = 1'b0;
      retire_mem_en_i = 2'b01; step(); retire_mem_en_i = 2'b00;

      // sw 0x200, with one rejected attempt
      disp(2'b01, OP_STORE, 3'b010, 3'b000, 6'd0, 6'd0);
      exec(32'h200, 32'h0, 32'h12345678);
      check("sw_done", 64'(done_o), 64'd1);
      check("sw_wr", 64'(regfile_wr_en_o), 64'd0);
      check("sw_noissue", 64'(mem_command_o), 64'd0);
      complete_en_i = 1'b1; step(); complete_en_i = 1'b0;
      check("sw_cmpl", 64'(done_o), 64'd0);
      retire_mem_en_i = 2'b01; step(); retire_mem_en_i = 2'b00;
      check("sw_cmd", 64'(mem_command_o), 64'd2);
      check("sw_addr", 64'(mem_address_o), 64'h200);
      check("sw_wdata", mem_wdata_o, 64'h12345678);
      step();
      check("sw_reissue", 64'(mem_command_o), 64'd2);
      mem_response_i = 4'd1; step(); mem_response_i = 4'd0;
      check("sw_dbg_data", 64'(debug_store_data), 64'h12345678);
      check("sw_dbg_addr", 64'(debug_store_address), 64'h200);
      check("sw_idle", 64'(mem_command_o), 64'd0);

      // sb at 0x205 lands in byte lane 5
      disp(2'b01, OP_STORE, 3'b000, 3'b000, 6'd0, 6'd0);
      exec(32'h205, 32'h0, 32'h000000AB);
      complete_en_i = 1'b1; retire_mem_en_i = 2'b01;
      step();
      complete_en_i = 1'b0; retire_mem_en_i = 2'b00;
      check("sb_addr", 64'(mem_address_o), 64'h200);
      check("sb_size", 64'(mem_size_o), 64'd0);
      check("sb_wdata", mem_wdata_o, 64'h0000AB00_00000000);
      mem_response_i = 4'd1; step(); mem_response_i = 4'd0;
      check("sb_dbg_addr", 64'(debug_store_address), 64'h205);

      // fill to the brim (pointers wrap here)
      for (int i = 0; i < 3; i++)
         disp(2'b11, OP_LOAD, 3'b010, 3'b010, 6'd1, 6'd2);
      check("fill6", 64'(lsq_full), 64'(FULL_NONE));
      disp(2'b01, OP_LOAD, 3'b010, 3'b010, 6'd3, 6'd0);
      check("fill7", 64'(lsq_full), 64'(ONE_LEFT));
      disp(2'b11, OP_LOAD, 3'b010, 3'b010, 6'd4, 6'd4);
      check("fill8", 64'(lsq_full), 64'(FULL));
      disp(2'b11, OP_LOAD, 3'b010, 3'b010, 6'd6, 6'd6);
      check("fill_extra", 64'(lsq_full), 64'(FULL));
      branch_recover_i = 2'b10; step(); branch_recover_i = 2'b00;
      check("fill_flush", 64'(lsq_full), 64'(FULL_NONE));

      // flush keeps the retired store at head
      disp(2'b01, OP_STORE, 3'b010, 3'b000, 6'd0, 6'd0);
      exec(32'h300, 32'h0, 32'h55);
      complete_en_i = 1'b1; retire_mem_en_i = 2'b01;
      step();
      complete_en_i = 1'b0; retire_mem_en_i = 2'b00;
      disp(2'b11, OP_LOAD, 3'b010, 3'b010, 6'd9, 6'd10);
      disp(2'b01, OP_LOAD, 3'b010, 3'b010, 6'd11, 6'd0);
      check("br_ready_pre", 64'(ready_o), 64'd1);
      branch_recover_i = 2'b01; step(); branch_recover_i = 2'b00;
      check("br_ready", 64'(ready_o), 64'd0);
      check("br_full", 64'(lsq_full), 64'(FULL_NONE));
      check("br_store_kept", 64'(mem_command_o), 64'd2);
      mem_response_i = 4'd1; step(); mem_response_i = 4'd0;
      check("br_store_sent", 64'(debug_store_address), 64'h300);
      check("br_empty_cmd", 64'(mem_command_o), 64'd0);
      check("br_empty_ready", 64'(ready_o), 64'd0);

      // reset with a load outstanding
      disp(2'b01, OP_LOAD, 3'b010, 3'b000, 6'd12, 6'd0);
      exec(32'h400, 32'h0, 32'h0);
      mem_response_i = 4'd4; step(); mem_response_i = 4'd0;
      reset = 1'b1; step(); reset = 1'b0;
      mem_tag_i = 4'd4; mem_data_i = 64'h11223344;
      step();
      mem_tag_i = 4'd0;
      check("rst_req_done", 64'(done_o), 64'd0);
      check("rst_req_wr", 64'(regfile_wr_en_o), 64'd0);
      check("rst_req_ready", 64'(ready_o), 64'd0);
      check("rst_req_cmd", 64'(mem_command_o), 64'd0);
      check("rst_req_res", 64'(result_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
